// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider / tick generator.
// Divisor and mode writes are double-buffered and applied only at a terminal count.
module clk_div_bank #(
    parameter int unsigned CH          = 4,
    parameter int unsigned W           = 26,
    parameter int unsigned DEFAULT_DIV = 25000000,
    localparam int unsigned CHW        = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [CH-1:0]  en,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [W-1:0]   cfg_div,
    input  logic           cfg_mode,
    output logic [CH-1:0]  clk_div,
    output logic [CH-1:0]  tick,
    output logic [CH-1:0]  cfg_pend
);

    localparam logic [W-1:0] DIV_RST = W'(DEFAULT_DIV);

    logic [W-1:0]  r_cnt      [CH];
    logic [W-1:0]  r_div_act  [CH];
    logic [W-1:0]  r_div_pend [CH];
    logic [CH-1:0] r_mode_act;
    logic [CH-1:0] r_mode_pend;
    logic [CH-1:0] r_pend;
    logic [CH-1:0] r_clk_div;
    logic [CH-1:0] r_tick;

    logic [CH-1:0] w_tc;
    logic [CH-1:0] w_wr;

    // Out-of-range cfg_ch values never match any channel index, so they are dropped here.
    always_comb begin
        w_tc = '0;
        w_wr = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            w_tc[i] = en[i] && (r_cnt[i] == r_div_act[i]);
            w_wr[i] = cfg_we && (cfg_ch == CHW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < CH; i++) begin
                r_cnt[i]      <= '0;
                r_div_act[i]  <= DIV_RST;
                r_div_pend[i] <= DIV_RST;
            end
            r_mode_act  <= '0;
            r_mode_pend <= '0;
            r_pend      <= '0;
            r_clk_div   <= '0;
            r_tick      <= '0;
        end else begin
            for (int unsigned i = 0; i < CH; i++) begin
                if (en[i]) begin
                    if (w_tc[i]) begin
                        r_cnt[i]     <= '0;
                        r_tick[i]    <= 1'b1;
                        r_clk_div[i] <= r_mode_act[i] ? 1'b1 : ~r_clk_div[i];
                    end else begin
                        r_cnt[i]  <= r_cnt[i] + 1'b1;
                        r_tick[i] <= 1'b0;
                        if (r_mode_act[i]) begin
                            r_clk_div[i] <= 1'b0;
                        end
                    end
                end else begin
                    r_tick[i] <= 1'b0;
                end

                // Apply uses the old mode for this edge's output, except a toggle->pulse
                // switch, which parks the output low so the first pulse starts clean.
                if (w_tc[i] && r_pend[i]) begin
                    if (!r_mode_act[i] && r_mode_pend[i]) begin
                        r_clk_div[i] <= 1'b0;
                    end
                    r_div_act[i]  <= r_div_pend[i];
                    r_mode_act[i] <= r_mode_pend[i];
                    r_pend[i]     <= 1'b0;
                end

                // A write landing on the applying edge stays pending for the next period.
                if (w_wr[i]) begin
                    r_div_pend[i]  <= cfg_div;
                    r_mode_pend[i] <= cfg_mode;
                    r_pend[i]      <= 1'b1;
                end
            end
        end
    end

    assign clk_div  = r_clk_div;
    assign tick     = r_tick;
    assign cfg_pend = r_pend;

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: a per-cycle reference model queues expected outputs,
// and each scenario task pops and compares them alongside directed timing checks.
module tb_clk_div_bank;

    localparam int CH   = 3;
    localparam int W    = 8;
    localparam int DDIV = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] en;
    logic          cfg_we;
    logic [1:0]    cfg_ch;
    logic [W-1:0]  cfg_div;
    logic          cfg_mode;
    logic [CH-1:0] clk_div;
    logic [CH-1:0] tick;
    logic [CH-1:0] cfg_pend;

    always #5 clk = ~clk;

    clk_div_bank #(.CH(CH), .W(W), .DEFAULT_DIV(DDIV)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_mode(cfg_mode), .clk_div(clk_div),
        .tick(tick), .cfg_pend(cfg_pend)
    );

    typedef struct packed {
        logic [CH-1:0] c;
        logic [CH-1:0] t;
        logic [CH-1:0] p;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int m_cnt[CH], m_div[CH], m_pdiv[CH];
    bit m_mode[CH], m_pmode[CH], m_pend[CH], m_clk[CH], m_tick[CH];
    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Advance the model by one edge using the inputs currently driven, queue the
    // expected outputs, then let the DUT take the same edge.
    task automatic cyc();
        exp_t x;
        bit   tc, wr;
        for (int i = 0; i < CH; i++) begin
            if (rst) begin
                m_cnt[i] = 0; m_div[i] = DDIV; m_mode[i] = 0;
                m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
            end else begin
                tc = en[i] && (m_cnt[i] == m_div[i]);
                wr = cfg_we && (int'(cfg_ch) == i);
                if (en[i]) begin
                    if (tc) begin
                        m_cnt[i] = 0; m_tick[i] = 1;
                        m_clk[i] = m_mode[i] ? 1'b1 : !m_clk[i];
                    end else begin
                        m_cnt[i]++; m_tick[i] = 0;
                        if (m_mode[i]) m_clk[i] = 0;
                    end
                end else begin
                    m_tick[i] = 0;
                end
                if (tc && m_pend[i]) begin
                    if (!m_mode[i] && m_pmode[i]) m_clk[i] = 0;
                    m_div[i] = m_pdiv[i]; m_mode[i] = m_pmode[i]; m_pend[i] = 0;
                end
                if (wr) begin
                    m_pdiv[i] = int'(cfg_div); m_pmode[i] = cfg_mode; m_pend[i] = 1;
                end
            end
            x.c[i] = m_clk[i]; x.t[i] = m_tick[i]; x.p[i] = m_pend[i];
        end
        sb.push_back(x);
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = '1;
        repeat (3) begin
            cyc();
            e = sb.pop_front(); checks++;
            if ({clk_div, tick, cfg_pend} !== e) begin
                errors++; $display("FAIL sb_reset cycle %0d: got %b required %b", cycle, {clk_div, tick, cfg_pend}, e);
            end
            checks++;
            if ({clk_div, tick, cfg_pend} !== '0) begin
                errors++; $display("FAIL reset_zero: got %b required 0", {clk_div, tick, cfg_pend});
            end
        end
    endtask

    task automatic test_toggle();
        int first = -1, ntick = 0;
        logic c4 = 1'b0;
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            e = sb.pop_front(); checks++;
            if ({clk_div, tick, cfg_pend} !== e) begin
                errors++; $display("FAIL sb_toggle cycle %0d: got %b required %b", cycle, {clk_div, tick, cfg_pend}, e);
            end
            checks++;
            if (clk_div !== {CH{clk_div[0]}} || tick !== {CH{tick[0]}}) begin
                errors++; $display("FAIL lockstep k=%0d: got clk_div %b tick %b", k, clk_div, tick);
            end
            if (tick[0] === 1'b1) begin ntick++; if (first < 0) first = k; end
            if (k == 4) c4 = clk_div[0];
        end
        checks++;
        if (first != 4) begin errors++; $display("FAIL first_tc: got %0d required 4", first); end
        checks++;
        if (ntick != 4) begin errors++; $display("FAIL tick_count: got %0d required 4", ntick); end
        checks++;
        if (c4 !== 1'b1) begin errors++; $display("FAIL toggle_at_tc: got %b required 1", c4); end
    endtask

    task automatic test_pulse_reconfig();
        int fall = -1;
        cyc();
        e = sb.pop_front(); checks++;
        if ({clk_div, tick, cfg_pend} !== e) begin
            errors++; $display("FAIL sb_pulse_pre cycle %0d: got %b required %b", cycle, {clk_div, tick, cfg_pend}, e);
        end
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd1; cfg_mode = 1'b1;
        cyc();
        cfg_we = 1'b0;
        e = sb.pop_front(); checks++;
        if ({clk_div, tick, cfg_pend} !== e) begin
            errors++; $display("FAIL sb_pulse_wr cycle %0d: got %b required %b", cycle, {clk_div, tick, cfg_pend}, e);
        end
        checks++;
        if (cfg_pend !== 3'b010) begin errors++; $display("FAIL pend_rise: got %b required 010", cfg_pend); end
        for (int k = 1; k <= 12; k++) begin
            cyc();
            e = sb.pop_front(); checks++;
            if ({clk_div, tick, cfg_pend} !== e) begin
                errors++; $display("FAIL sb_pulse cycle %0d: got %b required %b", cycle, {clk_div, tick, cfg_pend}, e);
            end
            if (fall < 0 && cfg_pend[1] === 1'b0) fall = k;
            if (k >= 3) begin
                checks++;
                if (clk_div[1] !== ((k % 2) == 0)) begin
                    errors++; $display("FAIL pulse_pattern k=%0d: got %b required %b", k, clk_div[1], (k % 2) == 0);
                end
            end
        end
        checks++;
        if (fall != 2) begin errors++; $display("FAIL pend_fall: got %0d required 2", fall); end
    endtask

    task automatic test_pause();
        logic held;
        int   guard = 0;
        while (m_cnt[0] != 2 && guard < 20) begin
            cyc(); guard++;
            e = sb.pop_front(); checks++;
            if ({clk_div, tick, cfg_pend} !== e) begin
                errors++; $display("FAIL sb_pause_pre cycle %0d: got %b required %b", cycle, {clk_div, tick, cfg_pend}, e);
            end
        end
        checks++;
        if (guard >= 20) begin errors++; $display("FAIL pause_setup_timeout: got %0d cycles required <20", guard); end
        held = clk_div[0];
        en[0] = 1'b0;
        repeat (5) begin
            cyc();
            e = sb.pop_front(); checks++;
            if ({clk_div, tick, cfg_pend} !== e) begin
                errors++; $display("FAIL sb_pause cycle %0d: got %b required %b", cycle, {clk_div, tick, cfg_pend}, e);
            end
            checks++;
            if (clk_div[0] !== held || tick[0] !== 1'b0) begin
                errors++; $display("FAIL pause_hold: got clk %b tick %b required clk %b tick 0", clk_div[0], tick[0], held);
            end
        end
        en[0] = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            cyc();
            e = sb.pop_front(); checks++;
            if ({clk_div, tick, cfg_pend} !== e) begin
                errors++; $display("FAIL sb_resume cycle %0d: got %b required %b", cycle, {clk_div, tick, cfg_pend}, e);
            end
            checks++;
            if (tick[0] !== (k == 2)) begin
                errors++; $display("FAIL resume_tc k=%0d: got %b required %b", k, tick[0], k == 2);
            end
        end
    endtask

    task automatic test_write_tc();
        int n, guard = 0;
        int exp_per[3] = '{6, 3, 3};
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5; cfg_mode = 1'b0;
        cyc();
        cfg_we = 1'b0;
        e = sb.pop_front(); checks++;
        if ({clk_div, tick, cfg_pend} !== e) begin
            errors++; $display("FAIL sb_wtc_pre cycle %0d: got %b required %b", cycle, {clk_div, tick, cfg_pend}, e);
        end
        while (m_cnt[0] != m_div[0] && guard < 20) begin
            cyc(); guard++;
            e = sb.pop_front(); checks++;
            if ({clk_div, tick, cfg_pend} !== e) begin
                errors++; $display("FAIL sb_wtc_wait cycle %0d: got %b required %b", cycle, {clk_div, tick, cfg_pend}, e);
            end
        end
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2;
        cyc();
        cfg_we = 1'b0;
        e = sb.pop_front(); checks++;
        if ({clk_div, tick, cfg_pend} !== e) begin
            errors++; $display("FAIL sb_wtc cycle %0d: got %b required %b", cycle, {clk_div, tick, cfg_pend}, e);
        end
        checks++;
        if (tick[0] !== 1'b1 || cfg_pend[0] !== 1'b1) begin
            errors++; $display("FAIL wtc_edge: got tick %b pend %b required 1 1", tick[0], cfg_pend[0]);
        end
        for (int p = 0; p < 3; p++) begin
            if (p == 2) begin
                // back-to-back writes right after a tick: only the last is applied
                cfg_we = 1'b1; cfg_div = 8'd7;
            end
            n = 0;
            do begin
                cyc(); n++;
                if (p == 2 && n == 1) cfg_div = 8'd2;
                if (p == 2 && n == 2) cfg_we = 1'b0;
                e = sb.pop_front(); checks++;
                if ({clk_div, tick, cfg_pend} !== e) begin
                    errors++; $display("FAIL sb_wtc_per cycle %0d: got %b required %b", cycle, {clk_div, tick, cfg_pend}, e);
                end
            end while (tick[0] !== 1'b1 && n < 20);
            if (p == 2) begin
                n = 0;
                do begin
                    cyc(); n++;
                    e = sb.pop_front(); checks++;
                    if ({clk_div, tick, cfg_pend} !== e) begin
                        errors++; $display("FAIL sb_wtc_b2b cycle %0d: got %b required %b", cycle, {clk_div, tick, cfg_pend}, e);
                    end
                end while (tick[0] !== 1'b1 && n < 20);
            end
            checks++;
            if (n != exp_per[p]) begin
                errors++; $display("FAIL wtc_period%0d: got %0d required %0d", p, n, exp_per[p]);
            end
        end
        checks++;
        if (cfg_pend[0] !== 1'b0) begin errors++; $display("FAIL wtc_pend_clear: got %b required 0", cfg_pend[0]); end
    endtask

    task automatic test_invalid_div0();
        logic [CH-1:0] snap;
        logic          prev;
        int            guard = 0;
        snap = cfg_pend;
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd0; cfg_mode = 1'b1;
        cyc();
        cfg_we = 1'b0;
        e = sb.pop_front(); checks++;
        if ({clk_div, tick, cfg_pend} !== e) begin
            errors++; $display("FAIL sb_invalid cycle %0d: got %b required %b", cycle, {clk_div, tick, cfg_pend}, e);
        end
        checks++;
        if (cfg_pend !== snap) begin errors++; $display("FAIL invalid_ch: got %b required %b", cfg_pend, snap); end
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0; cfg_mode = 1'b0;
        cyc();
        cfg_we = 1'b0;
        e = sb.pop_front(); checks++;
        if ({clk_div, tick, cfg_pend} !== e) begin
            errors++; $display("FAIL sb_div0_wr cycle %0d: got %b required %b", cycle, {clk_div, tick, cfg_pend}, e);
        end
        while (cfg_pend[2] !== 1'b0 && guard < 10) begin
            cyc(); guard++;
            e = sb.pop_front(); checks++;
            if ({clk_div, tick, cfg_pend} !== e) begin
                errors++; $display("FAIL sb_div0_wait cycle %0d: got %b required %b", cycle, {clk_div, tick, cfg_pend}, e);
            end
        end
        prev = clk_div[2];
        repeat (6) begin
            cyc();
            e = sb.pop_front(); checks++;
            if ({clk_div, tick, cfg_pend} !== e) begin
                errors++; $display("FAIL sb_div0 cycle %0d: got %b required %b", cycle, {clk_div, tick, cfg_pend}, e);
            end
            checks++;
            if (tick[2] !== 1'b1 || clk_div[2] !== ~prev) begin
                errors++; $display("FAIL div0_toggle: got clk %b tick %b required clk %b tick 1", clk_div[2], tick[2], ~prev);
            end
            prev = clk_div[2];
        end
    endtask

    task automatic test_reset_mid();
        int first[CH] = '{-1, -1, -1};
        int ntick0 = 0;
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd9; cfg_mode = 1'b0;
        cyc();
        e = sb.pop_front(); checks++;
        if ({clk_div, tick, cfg_pend} !== e) begin
            errors++; $display("FAIL sb_rmid_wr cycle %0d: got %b required %b", cycle, {clk_div, tick, cfg_pend}, e);
        end
        rst = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd1; cfg_mode = 1'b1;
        cyc();
        rst = 1'b0; cfg_we = 1'b0;
        e = sb.pop_front(); checks++;
        if ({clk_div, tick, cfg_pend} !== e) begin
            errors++; $display("FAIL sb_rmid cycle %0d: got %b required %b", cycle, {clk_div, tick, cfg_pend}, e);
        end
        checks++;
        if ({clk_div, tick, cfg_pend} !== '0) begin
            errors++; $display("FAIL rmid_zero: got %b required 0", {clk_div, tick, cfg_pend});
        end
        for (int k = 1; k <= 8; k++) begin
            cyc();
            e = sb.pop_front(); checks++;
            if ({clk_div, tick, cfg_pend} !== e) begin
                errors++; $display("FAIL sb_rmid_run cycle %0d: got %b required %b", cycle, {clk_div, tick, cfg_pend}, e);
            end
            for (int i = 0; i < CH; i++) if (first[i] < 0 && tick[i] === 1'b1) first[i] = k;
            if (tick[0] === 1'b1) ntick0++;
            if (k == 4) begin
                checks++;
                if (clk_div !== '1) begin errors++; $display("FAIL rmid_toggle: got %b required 111", clk_div); end
            end
        end
        for (int i = 0; i < CH; i++) begin
            checks++;
            if (first[i] != 4) begin errors++; $display("FAIL rmid_first_tc ch%0d: got %0d required 4", i, first[i]); end
        end
        checks++;
        if (ntick0 != 2 || cfg_pend !== '0) begin
            errors++; $display("FAIL rmid_discard: got ticks %0d pend %b required 2 000", ntick0, cfg_pend);
        end
    endtask

    initial begin
        rst = 1'b1; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
        test_reset();
        test_toggle();
        test_pulse_reconfig();
        test_pause();
        test_write_tc();
        test_invalid_div0();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
